// File: rtl/uart_rx_front_pkg.sv
// Shared typedefs for the UART receive front end: 32-bit word types,
// the receiver state encoding and the default baud divisor.
package uart_rx_front_pkg;

  typedef logic [31:0] w32;
  typedef logic [31:0] r32;

  // 100 MHz system clock divided down to 115200 baud.
  localparam w32 DEFAULT_CLK_PER_BIT = 32'd868;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } rxState_e;

  // The ring buffer stores whole words, so received bytes are zero-extended.
  function automatic w32 zeroExtendByte(input logic [7:0] b);
    return {24'd0, b};
  endfunction

endpackage

// File: rtl/uart_rx_front_sync2.sv
// Two-flop synchronizer for a single asynchronous input. The reset value
// is a parameter so an idle-high serial line does not look like a start
// edge while the block comes out of reset.
module sync2
  import uart_rx_front_pkg::*;
#(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic r_meta;
  logic r_sync;

  // Capture the raw line, then give any metastability a full cycle to settle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule

// File: rtl/uart_rx_front.sv
// UART receive front end: synchronizes the serial line, frames 8N1
// characters by mid-bit sampling and hands each byte to the downstream
// ring buffer as a one-cycle write strobe. Broken stop bits raise a
// framing-error pulse and the receiver then waits for the line to return
// high before looking for the next start edge.
module uart_rx_front
  import uart_rx_front_pkg::*;
#(
  parameter w32   CLK_PER_BIT = DEFAULT_CLK_PER_BIT,
  parameter logic STOP_CHECK  = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic rxd,
  output logic we,
  output w32   wd,
  output logic ferr,
  output logic busy
);

  localparam w32 BIT_LAST  = CLK_PER_BIT - 32'd1;
  localparam w32 HALF_LAST = (CLK_PER_BIT >> 1) - 32'd1;

  logic       w_rxs;
  rxState_e   r_state;
  rxState_e   w_stateNext;
  w32         r_cnt;
  w32         w_cntNext;
  logic [2:0] r_idx;
  logic [2:0] w_idxNext;
  logic [7:0] r_shift;
  logic [7:0] w_shiftNext;
  logic       w_weNext;
  logic       w_ferrNext;
  logic       r_we;
  logic       r_ferr;
  w32         r_wd;

  sync2 #(
    .RESET_VAL(1'b1)
  ) uSync (
    .clock(clock),
    .reset(reset),
    .d    (rxd),
    .q    (w_rxs)
  );

  // Receiver state, bit-time counter, bit index and assembled byte.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
    end else begin
      r_state <= w_stateNext;
      r_cnt   <= w_cntNext;
      r_idx   <= w_idxNext;
      r_shift <= w_shiftNext;
    end
  end

  // Frame sequencing: the start bit is timed to its middle, after which
  // every data and stop bit is sampled one full bit time later, i.e. also
  // at its middle. The counter is cleared on every state change so it
  // never has to count past the end of a bit.
  always_comb begin
    w_stateNext = r_state;
    w_cntNext   = r_cnt;
    w_idxNext   = r_idx;
    w_shiftNext = r_shift;
    w_weNext    = 1'b0;
    w_ferrNext  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (!w_rxs) begin
          w_stateNext = START;
          w_cntNext   = '0;
        end
      end
      START: begin
        if (r_cnt == HALF_LAST) begin
          w_cntNext = '0;
          if (w_rxs) begin
            w_stateNext = IDLE;
          end else begin
            w_stateNext = DATA;
            w_idxNext   = '0;
          end
        end else begin
          w_cntNext = r_cnt + 32'd1;
        end
      end
      DATA: begin
        if (r_cnt == BIT_LAST) begin
          w_cntNext           = '0;
          w_shiftNext[r_idx]  = w_rxs;
          w_idxNext           = r_idx + 3'd1;
          if (r_idx == 3'd7) begin
            w_stateNext = STOP;
          end
        end else begin
          w_cntNext = r_cnt + 32'd1;
        end
      end
      STOP: begin
        if (r_cnt == BIT_LAST) begin
          w_cntNext = '0;
          if (w_rxs || !STOP_CHECK) begin
            w_weNext    = 1'b1;
            w_stateNext = IDLE;
          end else begin
            w_ferrNext  = 1'b1;
            w_stateNext = WAIT_HIGH;
          end
        end else begin
          w_cntNext = r_cnt + 32'd1;
        end
      end
      WAIT_HIGH: begin
        if (w_rxs) begin
          w_stateNext = IDLE;
        end
      end
      default: begin
        w_stateNext = IDLE;
        w_cntNext   = '0;
      end
    endcase
  end

  // Registered strobes and the held output word; wd only changes together
  // with a write strobe so the ring buffer always sees a stable byte.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_we   <= 1'b0;
      r_ferr <= 1'b0;
      r_wd   <= '0;
    end else begin
      r_we   <= w_weNext;
      r_ferr <= w_ferrNext;
      if (w_weNext) begin
        r_wd <= zeroExtendByte(r_shift);
      end
    end
  end

  assign we   = r_we;
  assign ferr = r_ferr;
  assign wd   = r_wd;
  assign busy = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx_front.sv
// Self-checking bench for uart_rx_front at 16 clocks per bit. Two
// instances share the serial line: dutA checks the stop bit, dutB does not.
module tb_uart_rx_front;

  localparam int CPB = 16;
  // Nine and a half bit times from the start edge to mid-stop, plus the
  // synchronizer delay.
  localparam int LATENCY = (19 * CPB) / 2 + 2;
  localparam int LAT_TOL = 2;
  localparam int FRAME_CYCLES = 10 * CPB;
  localparam logic [31:0] FERR_CODE = 32'hFFFF_FFFF;

  logic        clock = 1'b0;
  logic        reset;
  logic        rxd;
  logic        weA, ferrA, busyA;
  logic [31:0] wdA;
  logic        weB, ferrB, busyB;
  logic [31:0] wdB;

  int checks = 0;
  int errors = 0;
  int cycle = 0;
  int overlapCount = 0;

  logic [31:0] obsA[$];
  logic [31:0] obsB[$];
  int          obsCycA[$];
  int          obsCycB[$];

  typedef struct {
    logic [7:0] data;
    logic       stopBit;
    int         expWeA;
    int         expFerrA;
    int         expWeB;
  } vec_t;

  vec_t vectors[6];

  uart_rx_front #(
    .CLK_PER_BIT(32'd16),
    .STOP_CHECK (1'b1)
  ) dutA (
    .clock(clock),
    .reset(reset),
    .rxd  (rxd),
    .we   (weA),
    .wd   (wdA),
    .ferr (ferrA),
    .busy (busyA)
  );

  uart_rx_front #(
    .CLK_PER_BIT(32'd16),
    .STOP_CHECK (1'b0)
  ) dutB (
    .clock(clock),
    .reset(reset),
    .rxd  (rxd),
    .we   (weB),
    .wd   (wdB),
    .ferr (ferrB),
    .busy (busyB)
  );

  // 10-unit clock period.
  always #5 clock = ~clock;

  // Free-running cycle stamp used for latency measurements.
  always @(posedge clock) cycle <= cycle + 1;

  // Record every strobe away from the active edge; a framing error is
  // logged as a reserved code so ordering against bytes is preserved.
  always @(negedge clock) begin
    if (weA) begin obsA.push_back(wdA); obsCycA.push_back(cycle); end
    if (ferrA) begin obsA.push_back(FERR_CODE); obsCycA.push_back(cycle); end
    if (weB) begin obsB.push_back(wdB); obsCycB.push_back(cycle); end
    if (ferrB) begin obsB.push_back(FERR_CODE); obsCycB.push_back(cycle); end
    if ((weA && ferrA) || (weB && ferrB)) overlapCount++;
  end

  // Hard stop in case something upstream of the checks never returns.
  initial begin
    #5000000;
    $display("[TB] FAIL watchdog expired before end of test");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  task automatic checkRange(input string name, input int actual, input int lo, input int hi);
    checks++;
    if (actual < lo || actual > hi) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d..%0d", name, actual, lo, hi);
    end
  endtask

  task automatic clearObs();
    obsA.delete();
    obsB.delete();
    obsCycA.delete();
    obsCycB.delete();
  endtask

  task automatic idleCycles(input int n);
    rxd = 1'b1;
    repeat (n) @(negedge clock);
  endtask

  // Drive one 8N1 character starting at the current falling edge of clock.
  task automatic applyStimulus(input logic [7:0] data, input logic stopVal, input int stopCycles, output int startCyc);
    startCyc = cycle;
    rxd = 1'b0;
    repeat (CPB) @(negedge clock);
    for (int b = 0; b < 8; b++) begin
      rxd = data[b];
      repeat (CPB) @(negedge clock);
    end
    rxd = stopVal;
    repeat (stopCycles) @(negedge clock);
  endtask

  task automatic tally(input bit useB, output int nWe, output int nFerr, output logic [31:0] firstWd, output int firstCyc);
    int n;
    logic [31:0] code;
    nWe = 0;
    nFerr = 0;
    firstWd = 32'hDEAD_BEEF;
    firstCyc = -1;
    n = useB ? obsB.size() : obsA.size();
    for (int i = 0; i < n; i++) begin
      code = useB ? obsB[i] : obsA[i];
      if (code == FERR_CODE) begin
        nFerr++;
      end else begin
        if (nWe == 0) begin
          firstWd = code;
          firstCyc = useB ? obsCycB[i] : obsCycA[i];
        end
        nWe++;
      end
    end
  endtask

  logic [31:0] lastA = 32'd0;
  logic [31:0] lastB = 32'd0;

  task automatic runVector(input int n);
    int sc, nWe, nFerr, cyc;
    logic [31:0] wdv;
    string tag;
    tag = $sformatf("vec%0d", n);
    clearObs();
    applyStimulus(vectors[n].data, vectors[n].stopBit, CPB, sc);
    idleCycles(3 * CPB);
    tally(1'b0, nWe, nFerr, wdv, cyc);
    checkOutput({tag, " weA count"}, nWe, vectors[n].expWeA);
    checkOutput({tag, " ferrA count"}, nFerr, vectors[n].expFerrA);
    if (vectors[n].expWeA != 0) begin
      lastA = {24'd0, vectors[n].data};
      checkOutput({tag, " wdA strobe"}, wdv, lastA);
      checkRange({tag, " latency A"}, cyc - sc, LATENCY - LAT_TOL, LATENCY + LAT_TOL);
    end
    checkOutput({tag, " wdA held"}, wdA, lastA);
    tally(1'b1, nWe, nFerr, wdv, cyc);
    checkOutput({tag, " weB count"}, nWe, vectors[n].expWeB);
    checkOutput({tag, " ferrB count"}, nFerr, 0);
    if (vectors[n].expWeB != 0) begin
      lastB = {24'd0, vectors[n].data};
      checkOutput({tag, " wdB strobe"}, wdv, lastB);
      checkRange({tag, " latency B"}, cyc - sc, LATENCY - LAT_TOL, LATENCY + LAT_TOL);
    end
    checkOutput({tag, " busyA idle"}, busyA, 1'b0);
    checkOutput({tag, " busyB idle"}, busyB, 1'b0);
  endtask

  logic [31:0] expA[$];
  logic [31:0] expB[$];
  int          startQ[$];

  initial begin
    int sc, s1, nWe, nFerr, cyc, nCmp;
    logic [31:0] wdv;
    logic [7:0] rdata;
    logic rstop;

    vectors[0] = '{8'hA5, 1'b1, 1, 0, 1};
    vectors[1] = '{8'h00, 1'b1, 1, 0, 1};
    vectors[2] = '{8'hFF, 1'b1, 1, 0, 1};
    vectors[3] = '{8'h3C, 1'b0, 0, 1, 1};
    vectors[4] = '{8'h81, 1'b1, 1, 0, 1};
    vectors[5] = '{8'h7E, 1'b0, 0, 1, 1};

    reset = 1'b0;
    rxd = 1'b1;
    repeat (4) @(negedge clock);
    checkOutput("reset weA", weA, 1'b0);
    checkOutput("reset ferrA", ferrA, 1'b0);
    checkOutput("reset busyA", busyA, 1'b0);
    checkOutput("reset wdA", wdA, 32'd0);
    checkOutput("reset busyB", busyB, 1'b0);
    checkOutput("reset wdB", wdB, 32'd0);
    reset = 1'b1;
    idleCycles(2 * CPB);

    for (int v = 0; v < 6; v++) runVector(v);

    // Back-to-back 0x00 then 0xFF with no idle time between frames.
    clearObs();
    applyStimulus(8'h00, 1'b1, CPB, sc);
    applyStimulus(8'hFF, 1'b1, CPB, s1);
    idleCycles(3 * CPB);
    checkOutput("b2b A event count", obsA.size(), 2);
    checkOutput("b2b A first", obsA.size() > 0 ? obsA[0] : 32'hDEAD_BEEF, 32'h0000_0000);
    checkOutput("b2b A second", obsA.size() > 1 ? obsA[1] : 32'hDEAD_BEEF, 32'h0000_00FF);
    checkRange("b2b A spacing", obsCycA.size() > 1 ? obsCycA[1] - obsCycA[0] : -1,
               FRAME_CYCLES - 2, FRAME_CYCLES + 2);
    lastA = 32'h0000_00FF;
    lastB = 32'h0000_00FF;

    // Short low glitch: must be rejected at the mid-start check.
    clearObs();
    rxd = 1'b0;
    repeat (4) @(negedge clock);
    checkOutput("glitch busyA during", busyA, 1'b1);
    rxd = 1'b1;
    repeat (2 + 1 + CPB / 2 + 1 - 4) @(negedge clock);
    checkOutput("glitch busyA after", busyA, 1'b0);
    checkOutput("glitch busyB after", busyB, 1'b0);
    idleCycles(2 * CPB);
    checkOutput("glitch A events", obsA.size(), 0);
    checkOutput("glitch B events", obsB.size(), 0);

    // Stop bit held low for 40 cycles on 0x3C: one framing error only.
    clearObs();
    applyStimulus(8'h3C, 1'b0, 40, sc);
    idleCycles(20 * CPB);
    tally(1'b0, nWe, nFerr, wdv, cyc);
    checkOutput("break weA count", nWe, 0);
    checkOutput("break ferrA count", nFerr, 1);
    checkOutput("break wdA held", wdA, lastA);
    clearObs();
    runVectorInline55();

    // Reset asserted in the middle of data bit 4 of 0x81.
    clearObs();
    rdata = 8'h81;
    rxd = 1'b0;
    repeat (CPB) @(negedge clock);
    for (int b = 0; b < 4; b++) begin
      rxd = rdata[b];
      repeat (CPB) @(negedge clock);
    end
    rxd = rdata[4];
    repeat (CPB / 2) @(negedge clock);
    checkOutput("pre-reset busyA", busyA, 1'b1);
    reset = 1'b0;
    #1;
    checkOutput("async reset weA", weA, 1'b0);
    checkOutput("async reset ferrA", ferrA, 1'b0);
    checkOutput("async reset busyA", busyA, 1'b0);
    checkOutput("async reset wdA", wdA, 32'd0);
    checkOutput("async reset busyB", busyB, 1'b0);
    checkOutput("async reset wdB", wdB, 32'd0);
    rxd = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    idleCycles(3 * CPB);
    checkOutput("aborted frame A events", obsA.size(), 0);
    checkOutput("aborted frame B events", obsB.size(), 0);
    lastA = 32'd0;
    lastB = 32'd0;
    runVector(4);

    // Randomized frames against the scoreboard model.
    clearObs();
    expA.delete();
    expB.delete();
    startQ.delete();
    for (int i = 0; i < 24; i++) begin
      rdata = 8'($urandom_range(0, 255));
      rstop = ($urandom_range(0, 3) != 0);
      expA.push_back(rstop ? {24'd0, rdata} : FERR_CODE);
      expB.push_back({24'd0, rdata});
      applyStimulus(rdata, rstop, CPB, sc);
      startQ.push_back(sc);
      idleCycles((2 + int'($urandom_range(0, 2))) * CPB);
    end
    checkOutput("random A event count", obsA.size(), expA.size());
    checkOutput("random B event count", obsB.size(), expB.size());
    nCmp = (obsA.size() < expA.size()) ? obsA.size() : expA.size();
    for (int i = 0; i < nCmp; i++) begin
      checkOutput($sformatf("random A event %0d", i), obsA[i], expA[i]);
      checkRange($sformatf("random A latency %0d", i), obsCycA[i] - startQ[i],
                 LATENCY - LAT_TOL, LATENCY + LAT_TOL);
    end
    nCmp = (obsB.size() < expB.size()) ? obsB.size() : expB.size();
    for (int i = 0; i < nCmp; i++) begin
      checkOutput($sformatf("random B event %0d", i), obsB[i], expB[i]);
    end

    checkOutput("we/ferr overlap", overlapCount, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Frame 0x55 after a line break: the receiver must have recovered.
  task automatic runVectorInline55();
    int sc, nWe, nFerr, cyc;
    logic [31:0] wdv;
    applyStimulus(8'h55, 1'b1, CPB, sc);
    idleCycles(3 * CPB);
    tally(1'b0, nWe, nFerr, wdv, cyc);
    checkOutput("post-break weA count", nWe, 1);
    checkOutput("post-break ferrA count", nFerr, 0);
    checkOutput("post-break wdA", wdv, 32'h0000_0055);
    checkRange("post-break latency A", cyc - sc, LATENCY - LAT_TOL, LATENCY + LAT_TOL);
    tally(1'b1, nWe, nFerr, wdv, cyc);
    checkOutput("post-break wdB", wdv, 32'h0000_0055);
    lastA = 32'h0000_0055;
    lastB = 32'h0000_0055;
  endtask

endmodule
